// File: rtl/popcount_pattern_gen_pkg.sv
// Shared types and helpers for the ones-count pattern generator.
package popgen_pkg;

  // Widest pattern the block supports; top_mask is sized to it.
  localparam int POPGEN_WMAX  = 8;
  localparam int POPGEN_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Largest WIDTH-bit value with k bits set: k ones packed into the MSBs.
  // Gives 0 when k is 0. The caller must keep k <= width.
  function automatic logic [POPGEN_WMAX-1:0] top_mask(input int k, input int width);
    int m;
    m = ((1 << k) - 1) << (width - k);
    return m[POPGEN_WMAX-1:0];
  endfunction

endpackage

// File: rtl/popcount_pattern_gen_popcount_w.sv
// Combinational ones counter: number of set bits in a W-bit word.
module popcount_w #(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count
);

  // Add up the bits one at a time.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end

endmodule

// File: rtl/popcount_pattern_gen.sv
// Ones-count pattern generator: for a requested k, emits every WIDTH-bit
// vector with exactly k bits set, in ascending order, one per handshake.
// Optional build macro POPGEN_ABORT_EN adds an abort input that drops the
// current sequence and returns to IDLE.
module popcount_pattern_gen
  import popgen_pkg::*;
#(
  parameter  int WIDTH = POPGEN_WIDTH,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
`ifdef POPGEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             req_valid,
  input  logic [CW-1:0]    req_count,
  output logic             req_ready,
  output logic             req_err,
  output logic             pat_valid,
  output logic [WIDTH-1:0] pat_data,
  output logic             pat_last,
  input  logic             pat_ready
);

  state_t                   r_state;
  logic [WIDTH-1:0]         r_cand;
  logic [CW-1:0]            r_k;
  // Low on the first cycle in SCAN; candidates are only judged once it is set.
  logic                     r_prime;
  logic                     r_pat_valid;
  logic [WIDTH-1:0]         r_pat_data;
  logic                     r_pat_last;
  logic                     r_req_err;

  logic [CW-1:0]            w_ones;
  logic                     w_hit;
  logic [POPGEN_WMAX-1:0]   w_top;
  logic                     w_is_top;

  popcount_w #(.W(WIDTH), .CW(CW)) u_popcount (
    .i_data  (r_cand),
    .o_count (w_ones)
  );

  assign w_hit     = (w_ones == r_k);
  assign w_top     = top_mask(int'(r_k), WIDTH);
  assign w_is_top  = (POPGEN_WMAX'(r_cand) == w_top);

  assign req_ready = (r_state == IDLE) & ena;
  assign req_err   = r_req_err;
  assign pat_valid = r_pat_valid;
  assign pat_data  = r_pat_data;
  assign pat_last  = r_pat_last;

  // Request intake, candidate scan and pattern handshake; freezes while ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_k         <= '0;
      r_prime     <= 1'b0;
      r_pat_valid <= 1'b0;
      r_pat_data  <= '0;
      r_pat_last  <= 1'b0;
      r_req_err   <= 1'b0;
    end else if (ena) begin
      r_req_err <= 1'b0;
`ifdef POPGEN_ABORT_EN
      if (abort && (r_state != IDLE)) begin
        r_state     <= IDLE;
        r_pat_valid <= 1'b0;
        r_pat_last  <= 1'b0;
      end else
`endif
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (req_count > CW'(WIDTH)) begin
              r_req_err <= 1'b1;
            end else begin
              r_k     <= req_count;
              r_cand  <= '0;
              r_prime <= 1'b0;
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (!r_prime) begin
            r_prime <= 1'b1;
          end else if (w_hit) begin
            r_pat_data  <= r_cand;
            r_pat_valid <= 1'b1;
            r_pat_last  <= w_is_top;
            r_state     <= EMIT;
          end else begin
            r_cand <= r_cand + WIDTH'(1);
          end
        end
        EMIT: begin
          if (pat_ready) begin
            r_pat_valid <= 1'b0;
            r_pat_last  <= 1'b0;
            if (r_pat_last) begin
              r_state <= IDLE;
            end else begin
              r_cand  <= r_cand + WIDTH'(1);
              r_prime <= 1'b0;
              r_state <= SCAN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Directed bench for popcount_pattern_gen at WIDTH=4.
module tb_popcount_pattern_gen;
  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b1;
  logic             req_valid = 1'b0;
  logic [CW-1:0]    req_count = '0;
  logic             req_ready;
  logic             req_err;
  logic             pat_valid;
  logic [WIDTH-1:0] pat_data;
  logic             pat_last;
  logic             pat_ready = 1'b0;
`ifdef POPGEN_ABORT_EN
  logic             abort = 1'b0;
`endif

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  popcount_pattern_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
`ifdef POPGEN_ABORT_EN
    .abort     (abort),
`endif
    .req_valid (req_valid),
    .req_count (req_count),
    .req_ready (req_ready),
    .req_err   (req_err),
    .pat_valid (pat_valid),
    .pat_data  (pat_data),
    .pat_last  (pat_last),
    .pat_ready (pat_ready)
  );

  // Presents a request for one cycle; t_acc is the accept-edge index.
  task automatic request(input logic [CW-1:0] k, output int t_acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_count = k;
    @(negedge clk);
    t_acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; req_valid = 1'b0; pat_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({pat_valid, pat_last, req_err, pat_data} !== 7'd0) begin
      $display("FAIL reset_outputs: got %b required 0000000", {pat_valid, pat_last, req_err, pat_data});
      n_err++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_req_ready_ena1: got %b required 1", req_ready);
      n_err++;
    end
    ena = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      $display("FAIL reset_req_ready_ena0: got %b required 0", req_ready);
      n_err++;
    end
    ena = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_k2();
    logic [3:0] exp_d [6];
    int exp_lat [6];
    int t_ref, w;
    exp_d   = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
    exp_lat = '{5, 3, 2, 4, 2, 3};
    pat_ready = 1'b1;
    request(3'd2, t_ref);
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (pat_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      n_vec++;
      if (pat_valid !== 1'b1) begin
        $display("FAIL k2_timeout beat %0d: pat_valid=%b required 1", i, pat_valid);
        n_err++;
        return;
      end
      n_vec++;
      if (pat_data !== exp_d[i]) begin
        $display("FAIL k2_data beat %0d: got %h required %h", i, pat_data, exp_d[i]);
        n_err++;
      end
      n_vec++;
      if (pat_last !== (i == 5)) begin
        $display("FAIL k2_last beat %0d: got %b required %b", i, pat_last, (i == 5));
        n_err++;
      end
      n_vec++;
      if (cyc - t_ref !== exp_lat[i]) begin
        $display("FAIL k2_latency beat %0d: got %0d required %0d", i, cyc - t_ref, exp_lat[i]);
        n_err++;
      end
      @(negedge clk);
      t_ref = cyc;
    end
    n_vec++;
    if (req_ready !== 1'b1 || pat_valid !== 1'b0) begin
      $display("FAIL k2_return_idle: req_ready=%b pat_valid=%b required 1 0", req_ready, pat_valid);
      n_err++;
    end
  endtask

  task automatic test_single_beat();
    logic [CW-1:0] ks [2];
    logic [3:0] exp_d [2];
    int exp_lat [2];
    int t_ref, w;
    ks = '{3'd0, 3'd4};
    exp_d = '{4'h0, 4'hF};
    exp_lat = '{2, 17};
    pat_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      request(ks[i], t_ref);
      w = 0;
      while (pat_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      n_vec++;
      if (pat_valid !== 1'b1) begin
        $display("FAIL single_timeout k=%0d: pat_valid=%b required 1", ks[i], pat_valid);
        n_err++;
        return;
      end
      n_vec++;
      if ({pat_last, pat_data} !== {1'b1, exp_d[i]}) begin
        $display("FAIL single_beat k=%0d: last,data got %b,%h required 1,%h", ks[i], pat_last, pat_data, exp_d[i]);
        n_err++;
      end
      n_vec++;
      if (cyc - t_ref !== exp_lat[i]) begin
        $display("FAIL single_latency k=%0d: got %0d required %0d", ks[i], cyc - t_ref, exp_lat[i]);
        n_err++;
      end
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1 || pat_valid !== 1'b0) begin
        $display("FAIL single_idle k=%0d: req_ready=%b pat_valid=%b required 1 0", ks[i], req_ready, pat_valid);
        n_err++;
      end
    end
  endtask

  task automatic test_err();
    int t_acc;
    pat_ready = 1'b1;
    request(3'd5, t_acc);
    n_vec++;
    if (req_err !== 1'b1 || pat_valid !== 1'b0) begin
      $display("FAIL err_pulse: req_err=%b pat_valid=%b required 1 0", req_err, pat_valid);
      n_err++;
    end
    @(negedge clk);
    n_vec++;
    if (req_err !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL err_clear: req_err=%b req_ready=%b required 0 1", req_err, req_ready);
      n_err++;
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (pat_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL err_stay_idle: pat_valid=%b req_ready=%b required 0 1", pat_valid, req_ready);
      n_err++;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_d [4];
    int exp_lat [4];
    int t_ref, w;
    exp_d = '{4'h1, 4'h2, 4'h4, 4'h8};
    exp_lat = '{3, 2, 3, 5};
    pat_ready = 1'b1;
    request(3'd1, t_ref);
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (pat_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      n_vec++;
      if (pat_valid !== 1'b1) begin
        $display("FAIL bp_timeout beat %0d: pat_valid=%b required 1", i, pat_valid);
        n_err++;
        return;
      end
      n_vec++;
      if ({pat_last, pat_data} !== {(i == 3), exp_d[i]} || cyc - t_ref !== exp_lat[i]) begin
        $display("FAIL bp_beat %0d: last,data,lat got %b,%h,%0d required %b,%h,%0d",
                 i, pat_last, pat_data, cyc - t_ref, (i == 3), exp_d[i], exp_lat[i]);
        n_err++;
      end
      if (i == 1) begin
        pat_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          n_vec++;
          if ({pat_valid, pat_last, pat_data} !== 6'b10_0010) begin
            $display("FAIL bp_hold stall %0d: valid,last,data got %b,%b,%h required 1,0,2", s, pat_valid, pat_last, pat_data);
            n_err++;
          end
        end
        pat_ready = 1'b1;
      end
      @(negedge clk);
      t_ref = cyc;
    end
  endtask

  task automatic test_reset_mid();
    int t_ref, w;
    pat_ready = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      request(3'd3, t_ref);
      w = 0;
      while (pat_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      n_vec++;
      if (pat_data !== 4'h7 || pat_last !== 1'b0 || cyc - t_ref !== 9) begin
        $display("FAIL rstmid_first pass %0d: data,last,lat got %h,%b,%0d required 7,0,9", pass, pat_data, pat_last, cyc - t_ref);
        n_err++;
      end
      rst = 1'b1;
      #1;
      if (pass == 0) begin
        n_vec++;
        if ({pat_valid, pat_last, req_err, pat_data} !== 7'd0) begin
          $display("FAIL rstmid_clear: got %b required 0000000", {pat_valid, pat_last, req_err, pat_data});
          n_err++;
        end
      end
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_ena_stall();
    logic [3:0] exp_d [4];
    int exp_lat [4];
    int t_ref, w;
    exp_d = '{4'h7, 4'hB, 4'hD, 4'hE};
    exp_lat = '{13, 9, 7, 6};
    pat_ready = 1'b1;
    request(3'd3, t_ref);
    for (int i = 0; i < 4; i++) begin
      ena = 1'b0;
      repeat (4) begin
        @(negedge clk);
        n_vec++;
        if (pat_valid !== 1'b0) begin
          $display("FAIL ena_hold beat %0d: pat_valid=%b required 0", i, pat_valid);
          n_err++;
        end
      end
      ena = 1'b1;
      w = 0;
      while (pat_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
      n_vec++;
      if ({pat_valid, pat_last, pat_data} !== {1'b1, (i == 3), exp_d[i]} || cyc - t_ref !== exp_lat[i]) begin
        $display("FAIL ena_beat %0d: valid,last,data,lat got %b,%b,%h,%0d required 1,%b,%h,%0d",
                 i, pat_valid, pat_last, pat_data, cyc - t_ref, (i == 3), exp_d[i], exp_lat[i]);
        n_err++;
      end
      @(negedge clk);
      t_ref = cyc;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ena_return_idle: req_ready=%b required 1", req_ready);
      n_err++;
    end
  endtask

`ifdef POPGEN_ABORT_EN
  task automatic test_abort();
    int t_ref, w;
    pat_ready = 1'b1;
    request(3'd2, t_ref);
    w = 0;
    while (pat_valid !== 1'b1 && w < 40) begin @(negedge clk); w++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (pat_valid !== 1'b0 || pat_last !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL abort_idle: valid,last,ready got %b,%b,%b required 0,0,1", pat_valid, pat_last, req_ready);
      n_err++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_k2();
    test_single_beat();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_ena_stall();
`ifdef POPGEN_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/popcount_pattern_gen.md
Name: popcount_pattern_gen

Overview:
- Inverse of the team's 4-input ones-count classifier. That block maps an input vector to how many of its bits are set; this block takes a ones-count and generates every WIDTH-bit vector with exactly that many bits set.
- Patterns are emitted one per output handshake, in ascending numeric order.
- Used as the on-chip stimulus source that drives the classifier's inputs.

Parameters:
- WIDTH, 4, pattern width in bits; legal range 2..8.
- CW, $clog2(WIDTH+1), width of the count field (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all flops on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global enable; when 0, all state and outputs hold.
- req_valid  in  1  count request valid.
- req_count  in  CW  requested number of set bits, k.
- req_ready  out  1  block can accept a request.
- req_err  out  1  one-cycle pulse: accepted request had k > WIDTH.
- pat_valid  out  1  pat_data is valid.
- pat_data  out  WIDTH  generated pattern.
- pat_last  out  1  asserted with the final pattern for this k.
- pat_ready  in  1  downstream accepts the pattern.

Behaviour:
- Reset (async, rst=1): state=IDLE, cand=0, k_reg=0; pat_valid=0, pat_data=0, pat_last=0, req_err=0.
- req_ready = (state==IDLE) & ena. This is combinational, so it reads 1 during reset if ena=1.
- Handshakes:
  - A request is accepted when req_valid & req_ready are high at a rising edge.
  - A pattern is accepted when pat_valid & pat_ready & ena are high at a rising edge.
- ena=0: no state changes, outputs hold, no handshake completes.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - On an accepted request with req_count > WIDTH: req_err=1 for exactly one cycle; stay in IDLE.
  - On an accepted request otherwise: k_reg=req_count, cand=0, go to SCAN.
- SCAN (one candidate evaluated per cycle):
  - If popcount(cand)==k_reg: pat_data=cand, pat_valid=1, pat_last=(cand == top mask), go to EMIT. The top mask is k_reg ones in the MSBs; for k=0 it is 0.
  - Otherwise: cand=cand+1.
  - cand never wraps, because the top mask is always hit before cand reaches 2^WIDTH-1.
- EMIT:
  - pat_data and pat_last are held stable while pat_valid=1 and pat_ready=0.
  - On a pattern handshake with pat_last=1: pat_valid=0, pat_last=0, go to IDLE.
  - On a pattern handshake with pat_last=0: pat_valid=0, cand=cand+1, go to SCAN.
- Latency:
  - First pat_valid appears (first matching cand value + 2) cycles after the request-accept edge.
  - After a handshake, the next pat_valid appears (gap to the next matching value + 1) cycles later.
- Beats per request: C(WIDTH, k).
- req_err and pattern output are mutually exclusive: pat_valid is never 1 in the cycle req_err=1.
- Reset mid-operation: immediate return to IDLE. No pat_last is issued for the truncated sequence.
- req_valid while busy is ignored (req_ready=0). Upstream must hold its request.

Optional Feature:
- Macro: POPGEN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 & ena=1 at an edge in SCAN or EMIT: go to IDLE, pat_valid=0, pat_last=0, and no handshake is counted that cycle.
  - abort has priority over a simultaneous pattern handshake.
  - abort in IDLE: no effect.
- Undefined:
  - No abort port.
  - A sequence ends only on its pat_last handshake or on rst.

Decomposition:
- Package popgen_pkg holds:
  - state enum {IDLE, SCAN, EMIT};
  - localparam default WIDTH=4;
  - function top_mask(k, WIDTH).
- Sub-module popcount_w: combinational WIDTH-bit ones counter with CW-bit output. SCAN uses it to compare against k_reg.

Test Plan (WIDTH=4):
- k=2 with pat_ready held 1 -> pat_data sequence 0x3,0x5,0x6,0x9,0xA,0xC; pat_last only on 0xC; 6 beats; req_ready returns 1 the cycle after the 0xC handshake.
- k=0 -> single beat 0x0 with pat_last=1, pat_valid 2 cycles after the accept edge.
- k=4 -> single beat 0xF with pat_last=1, pat_valid 17 cycles after the accept edge.
- k=5 -> req_err high for exactly 1 cycle, pat_valid stays 0, block remains in IDLE.
- k=1 with pat_ready low for 3 cycles while 0x2 is presented -> 0x2 held stable; sequence continues 0x4,0x8; pat_last on 0x8.
- k=3 with rst pulsed while 0x7 is pending -> all outputs 0 immediately; a new k=3 request restarts at 0x7.
- k=3, ena=0 for 4 cycles mid-SCAN -> same output sequence 0x7,0xB,0xD,0xE with every gap stretched by exactly 4 cycles.
